// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache with
// zero-latency load hits and single-line refill/writeback to memory.
//
// Ports
//   clk, rst      : clock, asynchronous active-low reset
//   Address       : byte address {tag, index, word, byte}
//   WriteDataM    : store data (byte stores use bits [7:0])
//   ReadEnable    : load request (wins over WriteEnable)
//   WriteEnable   : store request
//   ByteAddress   : 1 = byte access, 0 = word access
//   Value         : load result (combinational on a hit)
//   CacheStall    : hold request to the pipeline
//   MemRead       : line refill request
//   MemWrite      : line writeback request
//   AMem          : line address {tag, index} for the memory request
//   WriteLine     : victim line data for writeback
//   MemLine       : refill line data
//   MemReady      : memory completion, only looked at during WB/FILL
module dcache_wb #(
    parameter int WORD_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_LINES      = 4,
    localparam int BO     = $clog2(WORD_W / 8),
    localparam int WO     = $clog2(WORDS_PER_LINE),
    localparam int IX     = $clog2(NUM_LINES),
    localparam int LINE_W = WORD_W * WORDS_PER_LINE,
    localparam int LA_W   = ADDR_W - BO - WO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Address,
    input  logic [WORD_W-1:0] WriteDataM,
    input  logic              ReadEnable,
    input  logic              WriteEnable,
    input  logic              ByteAddress,
    output logic [WORD_W-1:0] Value,
    output logic              CacheStall,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [LA_W-1:0]   AMem,
    output logic [LINE_W-1:0] WriteLine,
    input  logic [LINE_W-1:0] MemLine,
    input  logic              MemReady
);

    localparam int TAG_W = LA_W - IX;
    localparam int BPW   = WORD_W / 8;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    state_t state;

    // Storage: data and tags carry no reset, only valid/dirty do.
    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    // Line address of the missing request, captured when the miss is taken
    // so that the refill lands correctly even if the inputs wander.
    logic [LA_W-1:0] req_la;

    // Address fields
    logic [TAG_W-1:0] a_tag;
    logic [IX-1:0]    a_ix;
    logic [WO-1:0]    a_word;
    logic [BO-1:0]    a_byte;

    assign a_byte = Address[BO-1:0];
    assign a_word = Address[BO +: WO];
    assign a_ix   = Address[BO+WO +: IX];
    assign a_tag  = Address[ADDR_W-1 -: TAG_W];

    logic [IX-1:0]    fill_ix;
    logic [TAG_W-1:0] fill_tag;

    assign fill_ix  = req_la[IX-1:0];
    assign fill_tag = req_la[LA_W-1:IX];

    logic hit, req, is_store, st_hit, miss;

    assign hit      = valid_q[a_ix] && (tag_q[a_ix] == a_tag);
    assign req      = ReadEnable || WriteEnable;
    assign is_store = WriteEnable && !ReadEnable;
    assign st_hit   = (state == IDLE) && is_store && hit;
    assign miss     = (state == IDLE) && req && !hit;

    assign CacheStall = (state != IDLE) || (req && !hit);

    // Load path: read the indexed line and pick word / byte lane.
    logic [LINE_W-1:0] line_rd;
    logic [WORD_W-1:0] word_rd;
    logic [7:0]        byte_rd;

    always_comb begin
        line_rd = data_q[a_ix];
        word_rd = line_rd[int'(a_word) * WORD_W +: WORD_W];
        byte_rd = word_rd[int'(a_byte) * 8 +: 8];
        Value   = ByteAddress ? WORD_W'(byte_rd) : word_rd;
    end

    // Store path: a byte store replicates the low byte and enables one lane.
    logic [WORD_W-1:0] st_data;
    logic [BPW-1:0]    st_be;

    always_comb begin
        st_data = ByteAddress ? {BPW{WriteDataM[7:0]}} : WriteDataM;
        st_be   = ByteAddress ? (BPW'(1) << a_byte) : '1;
    end

    // Data and tag arrays. Refill and store hit are mutually exclusive
    // because a store hit only happens in IDLE.
    always_ff @(posedge clk) begin
        if (state == FILL && MemReady) begin
            data_q[fill_ix] <= MemLine;
            tag_q[fill_ix]  <= fill_tag;
        end else if (st_hit) begin
            for (int b = 0; b < BPW; b++) begin
                if (st_be[b])
                    data_q[a_ix][int'(a_word) * WORD_W + b * 8 +: 8] <= st_data[b * 8 +: 8];
            end
        end
    end

    // Control FSM with registered memory-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            valid_q   <= '0;
            dirty_q   <= '0;
            AMem      <= '0;
            WriteLine <= '0;
            req_la    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (st_hit)
                        dirty_q[a_ix] <= 1'b1;
                    if (miss) begin
                        req_la <= Address[ADDR_W-1:BO+WO];
                        if (valid_q[a_ix] && dirty_q[a_ix]) begin
                            state     <= WB;
                            MemWrite  <= 1'b1;
                            AMem      <= {tag_q[a_ix], a_ix};
                            WriteLine <= data_q[a_ix];
                        end else begin
                            state   <= FILL;
                            MemRead <= 1'b1;
                            AMem    <= Address[ADDR_W-1:BO+WO];
                        end
                    end
                end
                WB: begin
                    if (MemReady) begin
                        // Victim and new line share the index.
                        MemWrite         <= 1'b0;
                        dirty_q[fill_ix] <= 1'b0;
                        MemRead          <= 1'b1;
                        AMem             <= req_la;
                        state            <= FILL;
                    end
                end
                FILL: begin
                    if (MemReady) begin
                        MemRead          <= 1'b0;
                        valid_q[fill_ix] <= 1'b1;
                        dirty_q[fill_ix] <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb at default parameters.
module tb_dcache_wb;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  Address;
    logic [31:0]  WriteDataM;
    logic         ReadEnable;
    logic         WriteEnable;
    logic         ByteAddress;
    logic [31:0]  Value;
    logic         CacheStall;
    logic         MemRead;
    logic         MemWrite;
    logic [27:0]  AMem;
    logic [127:0] WriteLine;
    logic [127:0] MemLine;
    logic         MemReady;

    int n_chk = 0;
    int n_bad = 0;

    dcache_wb dut (
        .clk        (clk),
        .rst        (rst),
        .Address    (Address),
        .WriteDataM (WriteDataM),
        .ReadEnable (ReadEnable),
        .WriteEnable(WriteEnable),
        .ByteAddress(ByteAddress),
        .Value      (Value),
        .CacheStall (CacheStall),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .AMem       (AMem),
        .WriteLine  (WriteLine),
        .MemLine    (MemLine),
        .MemReady   (MemReady)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; Address = '0; WriteDataM = '0; ReadEnable = 1'b0;
        WriteEnable = 1'b0; ByteAddress = 1'b0; MemLine = '0; MemReady = 1'b0;
        #12;
        chk("rst_stall", CacheStall, 1'b0);
        chk("rst_mrd", MemRead, 1'b0);
        chk("rst_mwr", MemWrite, 1'b0);
        rst = 1'b1;
        tick();

        // Cold word load to 0x44
        Address = 32'h44; ReadEnable = 1'b1;
        #1 chk("cold_stall", CacheStall, 1'b1);
        tick();
        chk("cold_mrd", MemRead, 1'b1);
        chk("cold_mwr", MemWrite, 1'b0);
        chk("cold_amem", AMem, 28'h4);
        MemLine = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        MemReady = 1'b1;
        tick();
        MemReady = 1'b0;
        chk("fill_mrd", MemRead, 1'b0);
        chk("fill_stall", CacheStall, 1'b0);
        chk("fill_val", Value, 32'h22222222);

        // Byte store 0xAB to 0x45, then loads
        ReadEnable = 1'b0; WriteEnable = 1'b1; ByteAddress = 1'b1;
        Address = 32'h45; WriteDataM = 32'h000000AB;
        #1 chk("sb_stall", CacheStall, 1'b0);
        tick();
        WriteEnable = 1'b0; ReadEnable = 1'b1; ByteAddress = 1'b0; Address = 32'h44;
        #1 chk("lw_val", Value, 32'h2222AB22);
        chk("lw_stall", CacheStall, 1'b0);
        ByteAddress = 1'b1; Address = 32'h47;
        #1 chk("lb_val", Value, 32'h00000022);
        ByteAddress = 1'b0; Address = 32'h4C;
        #1 chk("lw3_val", Value, 32'h44444444);

        // Both enables: treated as a load, nothing written
        Address = 32'h44; WriteEnable = 1'b1; WriteDataM = 32'hFFFFFFFF;
        tick();
        WriteEnable = 1'b0;
        #1 chk("prio_val", Value, 32'h2222AB22);

        // MemReady in IDLE is ignored
        ReadEnable = 1'b0; MemReady = 1'b1;
        tick();
        MemReady = 1'b0;
        chk("idle_rdy", {CacheStall, MemRead, MemWrite}, 3'b000);

        // Load 0x104 evicts dirty line at index 0
        ReadEnable = 1'b1; Address = 32'h104;
        #1 chk("wb_stall", CacheStall, 1'b1);
        tick();
        chk("wb_mwr", MemWrite, 1'b1);
        chk("wb_mrd", MemRead, 1'b0);
        chk("wb_amem", AMem, 28'h4);
        chk("wb_word1", WriteLine[63:32], 32'h2222AB22);
        tick();
        chk("wb_hold", {MemWrite, MemRead, CacheStall}, 3'b101);
        MemReady = 1'b1;
        tick();
        MemReady = 1'b0;
        chk("wb2f_mwr", MemWrite, 1'b0);
        chk("wb2f_mrd", MemRead, 1'b1);
        chk("wb2f_amem", AMem, 28'h10);
        MemLine = {32'hD4D4D4D4, 32'hC4C4C4C4, 32'hB0000104, 32'hA4A4A4A4};
        MemReady = 1'b1;
        tick();
        MemReady = 1'b0;
        chk("f104_stall", CacheStall, 1'b0);
        chk("f104_val", Value, 32'hB0000104);

        // Long FILL with MemReady low; enables drop halfway
        Address = 32'h84;
        #1 chk("long_stall", CacheStall, 1'b1);
        tick();
        chk("long_amem", AMem, 28'h8);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) ReadEnable = 1'b0;
            chk("long_hold", {CacheStall, MemRead, MemWrite}, 3'b110);
            tick();
        end

        // Reset mid-FILL
        rst = 1'b0; ReadEnable = 1'b0;
        #1 chk("rstf_mrd", MemRead, 1'b0);
        chk("rstf_stall", CacheStall, 1'b0);
        chk("rstf_mwr", MemWrite, 1'b0);
        #3 rst = 1'b1;
        tick();
        ReadEnable = 1'b1; Address = 32'h44;
        #1 chk("rmiss_stall", CacheStall, 1'b1);
        tick();
        chk("rmiss_mrd", MemRead, 1'b1);
        chk("rmiss_amem", AMem, 28'h4);
        MemReady = 1'b1;
        tick();
        MemReady = 1'b0; ReadEnable = 1'b0;

        // Store-miss on a cold cache
        rst = 1'b0;
        #2 rst = 1'b1;
        tick();
        WriteEnable = 1'b1; ByteAddress = 1'b0; Address = 32'h88; WriteDataM = 32'hDEADBEEF;
        #1 chk("sw_stall", CacheStall, 1'b1);
        tick();
        chk("sw_mrd", MemRead, 1'b1);
        chk("sw_amem", AMem, 28'h8);
        MemLine = '0; MemReady = 1'b1;
        tick();
        MemReady = 1'b0;
        chk("sw_replay", CacheStall, 1'b0);
        tick();
        WriteEnable = 1'b0; ReadEnable = 1'b1;
        #1 chk("sw_val", Value, 32'hDEADBEEF);
        chk("sw_hit", CacheStall, 1'b0);
        // Conflict on index 0 must write back the stored line
        Address = 32'h08;
        #1 chk("sw_evict_stall", CacheStall, 1'b1);
        tick();
        chk("sw_dirty_mwr", MemWrite, 1'b1);
        chk("sw_dirty_amem", AMem, 28'h8);
        chk("sw_dirty_word2", WriteLine[95:64], 32'hDEADBEEF);
        chk("sw_dirty_word0", WriteLine[31:0], 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
